// File: rtl/clk_period_meter_pkg.sv
// rtl/clk_period_meter_pkg.sv - shared types and configuration helpers for clk_period_meter
package clk_period_meter_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  // TIMEOUT_CYC-1 must be reachable by the counter while TIMEOUT_CYC itself still fits.
  function automatic bit timeout_cfg_ok(input int cnt_w, input longint timeout_cyc);
    return (timeout_cyc >= 2) && (timeout_cyc < (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// rtl/clk_period_meter_if.sv - measurement control and result bus of clk_period_meter
interface clk_period_meter_if
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             en;
  logic             sig;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             lock;
  logic             timeout;

  modport master (
    output en, sig,
    input  period, high_time, valid, lock, timeout
  );

  modport slave (
    input  en, sig,
    output period, high_time, valid, lock, timeout
  );
endinterface

// File: rtl/clk_period_meter_sync_edge_det.sv
// rtl/clk_period_meter_sync_edge_det.sv - input synchronizer plus delay flop with rise/fall strobes
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & dly_q;
endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures period/high time of a slow async signal with lock and timeout
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 65535,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  clk_period_meter_if.slave  meter
);
  localparam int             MW       = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_CNT);

  if (!timeout_cfg_ok(CNT_W, TIMEOUT_CYC) || SYNC_STAGES < 2) begin : g_cfg_err
    $error("clk_period_meter: invalid TIMEOUT_CYC or SYNC_STAGES");
  end

  logic rise, fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(meter.sig),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [MW-1:0]    match_q, match_d;
  logic             have_prev_q, have_prev_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;
  logic             timeout_q, timeout_d;

  logic [CNT_W-1:0]        cnt_inc;
  logic signed [CNT_W:0]   diff;
  logic [CNT_W:0]          abs_diff;
  logic                    in_tol;
  logic                    tmo_hit;

  always_comb begin
    cnt_inc  = cnt_q + 1'b1;
    diff     = $signed({1'b0, cnt_inc}) - $signed({1'b0, period_q});
    abs_diff = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
    in_tol   = (abs_diff <= (CNT_W + 1)'(TOL));
    tmo_hit  = (cnt_q == TMO_LAST);

    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_lat_d    = hi_lat_q;
    period_d    = period_q;
    high_d      = high_q;
    match_d     = match_q;
    have_prev_d = have_prev_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!meter.en) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      hi_lat_d    = '0;
      match_d     = '0;
      have_prev_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
        ST_ARM: begin
          if (rise) begin
            state_d  = ST_MEASURE;
            cnt_d    = '0;
            hi_lat_d = '0;
          end else if (tmo_hit) begin
            timeout_d = 1'b1;
            match_d   = '0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_MEASURE: begin
          cnt_d = cnt_inc;
          if (fall) hi_lat_d = cnt_inc;
          // A rise in the timeout cycle still closes the period.
          if (rise) begin
            period_d    = cnt_inc;
            high_d      = hi_lat_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = '0;
            hi_lat_d    = '0;
            have_prev_d = 1'b1;
            if (have_prev_q && in_tol)
              match_d = (match_q == LOCK_MAX) ? match_q : match_q + 1'b1;
            else
              match_d = '0;
          end else if (tmo_hit) begin
            state_d     = ST_ARM;
            timeout_d   = 1'b1;
            match_d     = '0;
            cnt_d       = '0;
            have_prev_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    lock_d = (match_d == LOCK_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_lat_q    <= '0;
      period_q    <= '0;
      high_q      <= '0;
      match_q     <= '0;
      have_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      lock_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_lat_q    <= hi_lat_d;
      period_q    <= period_d;
      high_q      <= high_d;
      match_q     <= match_d;
      have_prev_q <= have_prev_d;
      valid_q     <= valid_d;
      lock_q      <= lock_d;
      timeout_q   <= timeout_d;
    end
  end

  assign meter.period    = period_q;
  assign meter.high_time = high_q;
  assign meter.valid     = valid_q;
  assign meter.lock      = lock_q;
  assign meter.timeout   = timeout_q;
endmodule
